// File: rtl/ps2_key_event_queue.sv
// PS/2 set-2 byte stream -> {ext,make,code} key events in a FWFT FIFO; KEY_REPEAT_FILTER_EN adds a held-key filter.
// Latency: event on evt_*/last_* one clock after the code byte's key_en.
// Backpressure: evt_valid/evt_ready pop; events arriving while full are dropped and set overflow.

module ps2_kq_fifo #(
   parameter int W     = 10,
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push_vld,
   input  logic [W-1:0]           push_dat,
   output logic                   pop_vld,
   input  logic                   pop_rdy,
   output logic [W-1:0]           pop_dat,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign pop_vld = (count != '0);
   assign full    = (count == CW'(DEPTH));
   assign pop_dat = mem[rd_ptr];
   assign do_pop  = pop_vld & pop_rdy;
   // A full FIFO still accepts a write when the head leaves on the same edge.
   assign do_push = push_vld & (~full | do_pop);

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_dat;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + AW'(1);
         if (do_push && !do_pop)      count <= count + CW'(1);
         else if (!do_push && do_pop) count <= count - CW'(1);
      end
   end
endmodule

module ps2_key_event_queue #(
   parameter int DEPTH          = 8,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   key_en,
   input  logic [7:0]             key_data,
   output logic                   evt_valid,
   input  logic                   evt_ready,
   output logic [7:0]             evt_code,
   output logic                   evt_make,
   output logic                   evt_ext,
   output logic [7:0]             last_code,
   output logic                   last_make,
   output logic                   last_ext,
   output logic [$clog2(DEPTH):0] fifo_count,
   output logic                   overflow,
   output logic                   proto_err,
   output logic [8:0]             held_count
);
   typedef struct packed {
      logic       ext;
      logic       make;
      logic [7:0] code;
   } key_evt_t;

   typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXTBRK} state_t;

   localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

   state_t        state;
   state_t        nxt_state;
   logic [TW-1:0] tmo_cnt;
   key_evt_t      dec_evt;
   key_evt_t      head_evt;
   logic          is_ctrl;
   logic          tmo_hit;
   logic          emit;
   logic          dec_err;
   logic          accept;
   logic          fifo_full;
   logic          pop;

   assign is_ctrl = key_data inside {8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF};
   assign tmo_hit = (state != S_IDLE) && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
   assign pop     = evt_valid & evt_ready;

   always_comb begin
      nxt_state    = state;
      dec_err      = 1'b0;
      emit         = 1'b0;
      dec_evt.ext  = (state == S_EXT) || (state == S_EXTBRK);
      dec_evt.make = (state == S_IDLE) || (state == S_EXT);
      dec_evt.code = key_data;
      if (key_en) begin
         if (key_data == 8'hE0) begin
            nxt_state = S_EXT;
            dec_err   = (state != S_IDLE);
         end else if (key_data == 8'hF0) begin
            nxt_state = dec_evt.ext ? S_EXTBRK : S_BRK;
            dec_err   = (state == S_BRK) || (state == S_EXTBRK);
         end else if (is_ctrl) begin
            nxt_state = S_IDLE;
            dec_err   = (state != S_IDLE);
         end else begin
            nxt_state = S_IDLE;
            emit      = 1'b1;
         end
      end else if (tmo_hit) begin
         nxt_state = S_IDLE;
         dec_err   = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         tmo_cnt   <= '0;
         proto_err <= 1'b0;
         overflow  <= 1'b0;
         last_code <= 8'h00;
         last_make <= 1'b0;
         last_ext  <= 1'b0;
      end else begin
         state     <= nxt_state;
         tmo_cnt   <= (key_en || nxt_state == S_IDLE) ? '0 : tmo_cnt + TW'(1);
         proto_err <= dec_err;
         if (emit) begin
            last_code <= dec_evt.code;
            last_make <= dec_evt.make;
            last_ext  <= dec_evt.ext;
         end
         if (accept && fifo_full && !pop) overflow <= 1'b1;
      end
   end

`ifdef KEY_REPEAT_FILTER_EN
   logic [511:0] held;
   logic [8:0]   held_idx;

   assign held_idx = {dec_evt.ext, dec_evt.code};
   // Typematic repeats of a held key and breaks of keys never seen pressed are swallowed.
   assign accept   = emit & (dec_evt.make ? ~held[held_idx] : held[held_idx]);

   always_ff @(posedge clk) begin
      if (reset) begin
         held       <= '0;
         held_count <= 9'd0;
      end else if (accept) begin
         held[held_idx] <= dec_evt.make;
         held_count     <= dec_evt.make ? held_count + 9'd1 : held_count - 9'd1;
      end
   end
`else
   assign accept     = emit;
   assign held_count = 9'd0;
`endif

   ps2_kq_fifo #(
      .W     ($bits(key_evt_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push_vld (accept),
      .push_dat (dec_evt),
      .pop_vld  (evt_valid),
      .pop_rdy  (evt_ready),
      .pop_dat  (head_evt),
      .count    (fifo_count),
      .full     (fifo_full)
   );

   assign evt_code = head_evt.code;
   assign evt_make = head_evt.make;
   assign evt_ext  = head_evt.ext;
endmodule

// File: tb/tb_ps2_key_event_queue.sv
// Bench for ps2_key_event_queue: directed scenarios with literal expectations plus a random phase,
// all checked every cycle against a queue-based event model.
module tb_ps2_key_event_queue;
   localparam int DEPTH = 4;
   localparam int TMO   = 20;

   typedef struct packed {
      logic       ext;
      logic       make;
      logic [7:0] code;
   } ev_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       key_en = 1'b0;
   logic [7:0] key_data = 8'h00;
   logic       evt_ready = 1'b0;
   logic       evt_valid, evt_make, evt_ext, last_make, last_ext, overflow, proto_err;
   logic [7:0] evt_code, last_code;
   logic [$clog2(DEPTH):0] fifo_count;
   logic [8:0] held_count;

   int total = 0;
   int bad = 0;
   int perr_seen = 0;
   bit cmp_en = 1'b0;

   ps2_key_event_queue #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .reset(reset), .key_en(key_en), .key_data(key_data),
      .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
      .evt_make(evt_make), .evt_ext(evt_ext), .last_code(last_code),
      .last_make(last_make), .last_ext(last_ext), .fifo_count(fifo_count),
      .overflow(overflow), .proto_err(proto_err), .held_count(held_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit is_ctrl(input logic [7:0] b);
      case (b)
         8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // Reference model: prefix flags, idle-cycle count, and a queue of events.
   ev_t q[$];
   bit  m_ext, m_brk, m_ovf, m_perr, mp_err, mp_pop, mp_acc;
   int  m_idle;
   ev_t m_last, mp_e;
   int  m_held_n = 0;
`ifdef KEY_REPEAT_FILTER_EN
   bit  m_held [512];
`endif

   always @(posedge clk) begin
      if (reset) begin
         q.delete();
         m_ext = 0; m_brk = 0; m_ovf = 0; m_perr = 0; m_idle = 0;
         m_last = '0; m_held_n = 0;
`ifdef KEY_REPEAT_FILTER_EN
         for (int i = 0; i < 512; i++) m_held[i] = 0;
`endif
      end else begin
         mp_pop = evt_ready && (q.size() > 0);
         mp_err = 0;
         mp_acc = 0;
         if (key_en) begin
            m_idle = 0;
            if (key_data == 8'hE0) begin
               mp_err = m_ext | m_brk; m_ext = 1; m_brk = 0;
            end else if (key_data == 8'hF0) begin
               mp_err = m_brk; m_brk = 1;
            end else if (is_ctrl(key_data)) begin
               mp_err = m_ext | m_brk; m_ext = 0; m_brk = 0;
            end else begin
               mp_e = '{ext: m_ext, make: !m_brk, code: key_data};
               m_last = mp_e;
               mp_acc = 1;
               m_ext = 0; m_brk = 0;
            end
         end else if (m_ext | m_brk) begin
            m_idle++;
            if (m_idle == TMO) begin
               mp_err = 1; m_ext = 0; m_brk = 0; m_idle = 0;
            end
         end
`ifdef KEY_REPEAT_FILTER_EN
         if (mp_acc) begin
            if (mp_e.make == m_held[{mp_e.ext, mp_e.code}]) mp_acc = 0;
            else begin
               m_held[{mp_e.ext, mp_e.code}] = mp_e.make;
               m_held_n += mp_e.make ? 1 : -1;
            end
         end
`endif
         if (mp_pop) void'(q.pop_front());
         if (mp_acc) begin
            if (q.size() < DEPTH) q.push_back(mp_e);
            else m_ovf = 1;
         end
         m_perr = mp_err;
      end
   end

   always @(negedge clk) begin
      if (proto_err === 1'b1) perr_seen++;
      if (cmp_en) begin
         chk("evt_valid", evt_valid, q.size() > 0);
         if (q.size() > 0) chk("evt_head", {evt_ext, evt_make, evt_code}, q[0]);
         chk("last_evt", {last_ext, last_make, last_code}, m_last);
         chk("fifo_count", fifo_count, q.size());
         chk("overflow", overflow, m_ovf);
         chk("proto_err", proto_err, m_perr);
         chk("held_count", held_count, m_held_n);
      end
   end

   task automatic sync();
      @(posedge clk); #1;
   endtask

   task automatic send(input logic [7:0] b);
      key_en = 1'b1; key_data = b;
      sync();
      key_en = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      sync();
      cmp_en = 1'b1;
      sync();
      reset = 1'b0;
   endtask

   task automatic pop_expect(input string name, input logic [9:0] exp);
      @(negedge clk);
      chk(name, {evt_valid, evt_ext, evt_make, evt_code}, {1'b1, exp});
      sync();
      evt_ready = 1'b1;
      sync();
      evt_ready = 1'b0;
   endtask

   int p0;
   logic [7:0] codes [8];
   logic [7:0] ctrls [9];

   initial begin
      codes[0] = 8'h1C; codes[1] = 8'h75; codes[2] = 8'h12; codes[3] = 8'h5A;
      codes[4] = 8'h6B; codes[5] = 8'h29; codes[6] = 8'h14; codes[7] = 8'h11;
      ctrls[0] = 8'h00; ctrls[1] = 8'hAA; ctrls[2] = 8'hE1; ctrls[3] = 8'hEE; ctrls[4] = 8'hFA;
      ctrls[5] = 8'hFC; ctrls[6] = 8'hFD; ctrls[7] = 8'hFE; ctrls[8] = 8'hFF;

      // Reset state
      do_reset();
      @(negedge clk);
      chk("rst_outs", {evt_valid, evt_code, evt_make, evt_ext, last_code, last_make, last_ext,
                       overflow, proto_err}, 0);
      chk("rst_count", fifo_count, 0);
      sync();

      // Single make
      send(8'h1C);
      @(negedge clk);
      chk("t1_valid", evt_valid, 1);
      chk("t1_head", {evt_ext, evt_make, evt_code}, 10'h11C);
      chk("t1_last", last_code, 8'h1C);
      chk("t1_count", fifo_count, 1);
      sync();
      pop_expect("t1_pop", 10'h11C);

      // Break, extended make, extended break
      p0 = perr_seen;
      send(8'hF0); send(8'h1C);
      send(8'hE0); send(8'h75);
      send(8'hE0); send(8'hF0); send(8'h75);
      @(negedge clk);
      chk("t2_count", fifo_count, 3);
      sync();
      pop_expect("t2_e0", 10'h01C);
      pop_expect("t2_e1", 10'h375);
      pop_expect("t2_e2", 10'h275);
      chk("t2_no_err", perr_seen - p0, 0);

      // Overflow
      do_reset();
      for (int i = 0; i < DEPTH + 2; i++) send(8'h20 + 8'(i));
      @(negedge clk);
      chk("t3_count", fifo_count, DEPTH);
      chk("t3_ovf", overflow, 1);
      sync();
      for (int i = 0; i < DEPTH; i++) pop_expect("t3_pop", {2'b01, 8'h20 + 8'(i)});
      @(negedge clk);
      chk("t3_empty", evt_valid, 0);
      sync();

      // Timeout after E0
      do_reset();
      p0 = perr_seen;
      send(8'hE0);
      repeat (TMO + 3) sync();
      chk("t4_one_err", perr_seen - p0, 1);
      send(8'h1C);
      @(negedge clk);
      chk("t4_head", {evt_ext, evt_make, evt_code}, 10'h11C);
      sync();

      // Full FIFO, push coinciding with pop
      do_reset();
      for (int i = 0; i < DEPTH; i++) send(8'h40 + 8'(i));
      key_en = 1'b1; key_data = 8'h50; evt_ready = 1'b1;
      sync();
      key_en = 1'b0; evt_ready = 1'b0;
      @(negedge clk);
      chk("t5_count", fifo_count, DEPTH);
      chk("t5_ovf", overflow, 0);
      chk("t5_head", evt_code, 8'h41);
      sync();

`ifdef KEY_REPEAT_FILTER_EN
      // Typematic filter
      do_reset();
      send(8'h1C); send(8'h1C); send(8'h1C);
      @(negedge clk);
      chk("t6_held1", held_count, 1);
      sync();
      send(8'hF0); send(8'h1C);
      @(negedge clk);
      chk("t6_held0", held_count, 0);
      sync();
      send(8'hF0); send(8'h1C);
      @(negedge clk);
      chk("t6_count", fifo_count, 2);
      sync();
      pop_expect("t6_e0", 10'h11C);
      pop_expect("t6_e1", 10'h01C);
`endif

      // Random phase
      do_reset();
      for (int n = 0; n < 4000; n++) begin
         int r;
         reset = ($urandom_range(0, 399) == 0);
         evt_ready = (n < 1500) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 2) != 0);
         key_en = ($urandom_range(0, 2) == 0);
         r = $urandom_range(0, 9);
         case (r)
            0: key_data = 8'hE0;
            1: key_data = 8'hF0;
            2: key_data = ctrls[$urandom_range(0, 8)];
            3: key_data = 8'($urandom_range(0, 255));
            default: key_data = codes[$urandom_range(0, 7)];
         endcase
         sync();
         if ($urandom_range(0, 149) == 0) begin
            key_en = 1'b0;
            reset = 1'b0;
            repeat (TMO + 2) sync();
         end
      end
      reset = 1'b0; key_en = 1'b0;
      sync();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
